// File: rtl/axil_reset_ctrl_regs_pkg.sv
// Shared constants and types for the reset-control register block.
// Holds bus widths, register word indices, AXI response codes and the
// per-domain reset sequencer state encoding.
package axil_reset_ctrl_pkg;

   localparam int unsigned ADDR_W = 12;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;
   localparam int unsigned RESP_W = 2;
   localparam int unsigned IDX_W  = 10;

   // Register word indices, compared against addr[11:2]
   localparam logic [IDX_W-1:0] REG_TIMESTAMP = 10'h000;
   localparam logic [IDX_W-1:0] REG_RESET     = 10'h001;
   localparam logic [IDX_W-1:0] REG_STATUS    = 10'h002;

   localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
   localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ASSERT    = 2'd1,
      WAIT_DONE = 2'd2,
      DONE      = 2'd3
   } rst_state_t;

endpackage

// File: rtl/axil_reset_ctrl_regs_if.sv
// AXI4-Lite channel bundle for the reset-control register block.
// Carries AW, W, B, AR and R channel signals; master drives requests,
// slave drives readies and responses.
interface axil_reset_ctrl_regs_if;
   import axil_reset_ctrl_pkg::*;

   logic              awvalid;
   logic              awready;
   logic [ADDR_W-1:0] awaddr;
   logic              wvalid;
   logic              wready;
   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic              bvalid;
   logic              bready;
   logic [RESP_W-1:0] bresp;
   logic              arvalid;
   logic              arready;
   logic [ADDR_W-1:0] araddr;
   logic              rvalid;
   logic              rready;
   logic [DATA_W-1:0] rdata;
   logic [RESP_W-1:0] rresp;

   modport master (
      output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

endinterface

// File: rtl/axil_reset_ctrl_regs_fsm.sv
// Single reset-domain sequencer: assert for RESET_CYCLES, release, then
// wait for the domain's done level.
// Ports: clk, rst_n (async active-low), start (1-cycle request),
// mod_rst_done (domain done level), mod_rstn/busy/done (registered).
module reset_domain_fsm
   import axil_reset_ctrl_pkg::*;
#(
   parameter int unsigned RESET_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic mod_rst_done,
   output logic mod_rstn,
   output logic busy,
   output logic done
);

   localparam int unsigned CNT_W = $clog2(RESET_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESET_CYCLES - 1);

   rst_state_t state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic mod_rstn_next, busy_next, done_next;

   // Reset parks the domain in ASSERT so a full sequence runs after release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ASSERT;
         cnt      <= '0;
         mod_rstn <= 1'b0;
         busy     <= 1'b1;
         done     <= 1'b0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         mod_rstn <= mod_rstn_next;
         busy     <= busy_next;
         done     <= done_next;
      end
   end

   // Next state; outputs are decoded from the next state so they register in step
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_next = ASSERT;
               cnt_next   = '0;
            end
         end
         ASSERT: begin
            if (cnt == CNT_LAST) state_next = WAIT_DONE;
            else                 cnt_next   = cnt + CNT_W'(1);
         end
         WAIT_DONE: begin
            if (mod_rst_done) state_next = DONE;
         end
         default: state_next = IDLE;
      endcase
      mod_rstn_next = (state_next != ASSERT);
      busy_next     = (state_next == ASSERT) || (state_next == WAIT_DONE);
      done_next     = (state_next == DONE);
   end

endmodule

// File: rtl/axil_reset_ctrl_regs.sv
// AXI4-Lite responder for the reset-control register space.
// Ports: axil_aclk, axil_aresetn (async active-low), s_axil (AXI-Lite slave
// bundle), mod_rstn (per-domain active-low reset), mod_rst_done (per-domain
// done level, already synchronous to axil_aclk).
// Registers: 0x000 TIMESTAMP (RO), 0x004 RESET (W1 start / R busy),
// 0x008 STATUS (RO done); other offsets respond SLVERR.
module axil_reset_ctrl_regs
   import axil_reset_ctrl_pkg::*;
#(
   parameter int unsigned       NUM_DOMAIN      = 3,
   parameter int unsigned       RESET_CYCLES    = 16,
   parameter logic [DATA_W-1:0] BUILD_TIMESTAMP = 32'h01010000
) (
   input  logic                  axil_aclk,
   input  logic                  axil_aresetn,
   axil_reset_ctrl_regs_if.slave s_axil,
   output logic [NUM_DOMAIN-1:0] mod_rstn,
   input  logic [NUM_DOMAIN-1:0] mod_rst_done
);

   logic [IDX_W-1:0]      wr_idx;
   logic [NUM_DOMAIN-1:0] wr_bits;
   logic [NUM_DOMAIN-1:0] strb_mask_c;
   logic [NUM_DOMAIN-1:0] start_c;
   logic [NUM_DOMAIN-1:0] busy;
   logic [NUM_DOMAIN-1:0] done;
   logic                  wr_fire_c;
   logic [RESP_W-1:0]     wr_resp_c;
   logic [IDX_W-1:0]      rd_idx_c;
   logic [DATA_W-1:0]     rd_data_c;
   logic [RESP_W-1:0]     rd_resp_c;
   logic                  unused_bits;

   assign unused_bits = ^{s_axil.awaddr[1:0], s_axil.araddr[1:0], s_axil.wdata, s_axil.wstrb};

   // Byte strobe covering each domain bit
   always_comb begin
      strb_mask_c = '0;
      for (int i = 0; i < int'(NUM_DOMAIN); i++) strb_mask_c[i] = s_axil.wstrb[i/8];
   end

   // A dropped ready means that channel is captured; fire once both are held
   assign wr_fire_c = !s_axil.awready && !s_axil.wready && !s_axil.bvalid;
   assign wr_resp_c = (wr_idx == REG_TIMESTAMP || wr_idx == REG_RESET || wr_idx == REG_STATUS)
                      ? RESP_OKAY : RESP_SLVERR;
   // Busy domains mask out their start bit so a running sequence is never restarted
   assign start_c   = (wr_fire_c && wr_idx == REG_RESET) ? (wr_bits & ~busy) : '0;

   // Write channel: independent AW/W capture, single outstanding response
   always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
      if (!axil_aresetn) begin
         s_axil.awready <= 1'b1;
         s_axil.wready  <= 1'b1;
         s_axil.bvalid  <= 1'b0;
         s_axil.bresp   <= RESP_OKAY;
         wr_idx         <= '0;
         wr_bits        <= '0;
      end else begin
         if (s_axil.awvalid && s_axil.awready) begin
            wr_idx         <= s_axil.awaddr[ADDR_W-1:2];
            s_axil.awready <= 1'b0;
         end
         if (s_axil.wvalid && s_axil.wready) begin
            wr_bits       <= s_axil.wdata[NUM_DOMAIN-1:0] & strb_mask_c;
            s_axil.wready <= 1'b0;
         end
         if (wr_fire_c) begin
            s_axil.bvalid <= 1'b1;
            s_axil.bresp  <= wr_resp_c;
         end else if (s_axil.bvalid && s_axil.bready) begin
            s_axil.bvalid  <= 1'b0;
            s_axil.awready <= 1'b1;
            s_axil.wready  <= 1'b1;
         end
      end
   end

   // Read mux on the live address; sampled into rdata at the AR handshake
   assign rd_idx_c = s_axil.araddr[ADDR_W-1:2];
   always_comb begin
      rd_data_c = '0;
      rd_resp_c = RESP_OKAY;
      case (rd_idx_c)
         REG_TIMESTAMP: rd_data_c = BUILD_TIMESTAMP;
         REG_RESET:     rd_data_c = DATA_W'(busy);
         REG_STATUS:    rd_data_c = DATA_W'(done);
         default:       rd_resp_c = RESP_SLVERR;
      endcase
   end

   // Read channel: one outstanding read, response held until rready
   always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
      if (!axil_aresetn) begin
         s_axil.arready <= 1'b1;
         s_axil.rvalid  <= 1'b0;
         s_axil.rdata   <= '0;
         s_axil.rresp   <= RESP_OKAY;
      end else begin
         if (s_axil.arvalid && s_axil.arready) begin
            s_axil.arready <= 1'b0;
            s_axil.rvalid  <= 1'b1;
            s_axil.rdata   <= rd_data_c;
            s_axil.rresp   <= rd_resp_c;
         end else if (s_axil.rvalid && s_axil.rready) begin
            s_axil.rvalid  <= 1'b0;
            s_axil.arready <= 1'b1;
         end
      end
   end

   // One sequencer per reset domain
   for (genvar g = 0; g < int'(NUM_DOMAIN); g++) begin : g_dom
      reset_domain_fsm #(
         .RESET_CYCLES (RESET_CYCLES)
      ) u_fsm (
         .clk          (axil_aclk),
         .rst_n        (axil_aresetn),
         .start        (start_c[g]),
         .mod_rst_done (mod_rst_done[g]),
         .mod_rstn     (mod_rstn[g]),
         .busy         (busy[g]),
         .done         (done[g])
      );
   end

endmodule

// File: tb/tb_axil_reset_ctrl_regs.sv
// Bench for axil_reset_ctrl_regs: directed AXI-Lite traffic with expected
// responses queued at issue time and checked by a separate monitor, plus
// mod_rstn pulse-length tracking per domain.
module tb_axil_reset_ctrl_regs;
   import axil_reset_ctrl_pkg::*;

   localparam int unsigned ND = 3;
   localparam int unsigned RC = 16;
   localparam logic [31:0] TS = 32'h01010000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [ND-1:0] mod_rstn;
   logic [ND-1:0] rst_done;

   always #5 clk = ~clk;

   axil_reset_ctrl_regs_if bus ();

   axil_reset_ctrl_regs #(
      .NUM_DOMAIN      (ND),
      .RESET_CYCLES    (RC),
      .BUILD_TIMESTAMP (TS)
   ) dut (
      .axil_aclk    (clk),
      .axil_aresetn (rst_n),
      .s_axil       (bus),
      .mod_rstn     (mod_rstn),
      .mod_rst_done (rst_done)
   );

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
   } rsp_t;

   rsp_t       rq[$];
   logic [1:0] bq[$];
   rsp_t       mon_e;
   logic [1:0] mon_b;

   int total = 0;
   int bad   = 0;

   int cur[ND];
   int pulses[ND];
   int last[ND];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      total++;
      bad++;
      $display("FAIL %s: got timeout/unexpected expected handshake", nm);
   endtask

   // Response monitor: compares every completed B/R handshake with the queue head
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.rvalid && bus.rready) begin
            if (rq.size() == 0) fail_now("r_unexpected");
            else begin
               mon_e = rq.pop_front();
               chk("rdata", bus.rdata, mon_e.data);
               chk("rresp", 32'(bus.rresp), 32'(mon_e.resp));
            end
         end
         if (bus.bvalid && bus.bready) begin
            if (bq.size() == 0) fail_now("b_unexpected");
            else begin
               mon_b = bq.pop_front();
               chk("bresp", 32'(bus.bresp), 32'(mon_b));
            end
         end
      end
   end

   // Low-pulse length tracker; pulses cut by axil_aresetn are discarded
   always @(negedge clk) begin
      for (int i = 0; i < int'(ND); i++) begin
         if (!rst_n) cur[i] <= 0;
         else if (!mod_rstn[i]) cur[i] <= cur[i] + 1;
         else if (cur[i] != 0) begin
            last[i]   <= cur[i];
            pulses[i] <= pulses[i] + 1;
            cur[i]    <= 0;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain_r();
      for (int k = 0; k < 200 && rq.size() != 0; k++) tick(1);
      if (rq.size() != 0) begin
         fail_now("r_drain");
         rq.delete();
      end
   endtask

   task automatic drain_b();
      for (int k = 0; k < 200 && bq.size() != 0; k++) tick(1);
      if (bq.size() != 0) begin
         fail_now("b_drain");
         bq.delete();
      end
   endtask

   task automatic ar_phase(input logic [11:0] a);
      bit ok;
      ok = 0;
      bus.araddr  = a;
      bus.arvalid = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.arready) begin ok = 1; break; end
      end
      if (!ok) fail_now("ar_timeout");
      @(posedge clk);
      #1 bus.arvalid = 1'b0;
   endtask

   task automatic axi_read(input logic [11:0] a, input logic [31:0] ed,
                           input logic [1:0] er, input bit drain);
      rq.push_back('{ed, er});
      ar_phase(a);
      if (drain) drain_r();
   endtask

   // gap < 0: AW and W presented together; otherwise W follows AW by gap cycles.
   // rd_status issues a STATUS read right after the W handshake (expects 0x7).
   task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int gap, input logic [1:0] er, input bit drain,
                            input bit rd_status);
      bit ok;
      bq.push_back(er);
      bus.awaddr = a;
      bus.wdata  = d;
      bus.wstrb  = s;
      ok = 0;
      bus.awvalid = 1'b1;
      if (gap < 0) bus.wvalid = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.awready && (gap >= 0 || bus.wready)) begin ok = 1; break; end
      end
      if (!ok) fail_now("aw_timeout");
      @(posedge clk);
      #1;
      bus.awvalid = 1'b0;
      if (gap >= 0) begin
         bus.wvalid = 1'b0;
         tick(gap);
         ok = 0;
         bus.wvalid = 1'b1;
         for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.wready) begin ok = 1; break; end
         end
         if (!ok) fail_now("w_timeout");
         @(posedge clk);
         #1;
      end
      bus.wvalid = 1'b0;
      if (rd_status) begin
         rq.push_back('{32'h7, RESP_OKAY});
         ar_phase(12'h008);
         drain_r();
      end
      if (drain) drain_b();
   endtask

   int  p0, p1, p2;
   int  snap[ND];
   bit  stable_ok;

   initial begin
      bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0;
      bus.arvalid = 0; bus.araddr = '0; bus.bready = 1; bus.rready = 1;
      rst_done = '1;

      // Reset values
      #12;
      chk("rst_mod_rstn", 32'(mod_rstn), 32'h0);
      chk("rst_readies", {29'd0, bus.awready, bus.wready, bus.arready}, 32'h7);
      chk("rst_valids", {30'd0, bus.bvalid, bus.rvalid}, 32'h0);
      chk("rst_rdata", bus.rdata, 32'h0);
      chk("rst_resps", {28'd0, bus.bresp, bus.rresp}, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Power-up auto-sequence
      tick(30);
      for (int i = 0; i < int'(ND); i++) begin
         chk($sformatf("pwrup_pulses%0d", i), 32'(pulses[i]), 32'd1);
         chk($sformatf("pwrup_len%0d", i), 32'(last[i]), 32'(RC));
      end
      axi_read(12'h008, 32'h7, RESP_OKAY, 1);
      axi_read(12'h004, 32'h0, RESP_OKAY, 1);

      // Domain 1 reset, AW two cycles before W, STATUS read on the effect cycle
      rst_done[1] = 1'b0;
      p0 = pulses[0]; p1 = pulses[1]; p2 = pulses[2];
      axi_write(12'h004, 32'h2, 4'hF, 2, RESP_OKAY, 1, 1);
      tick(25);
      axi_read(12'h004, 32'h2, RESP_OKAY, 1);
      axi_read(12'h008, 32'h5, RESP_OKAY, 1);
      tick(20);
      rst_done[1] = 1'b1;
      tick(3);
      axi_read(12'h008, 32'h7, RESP_OKAY, 1);
      chk("d1_pulses", 32'(pulses[1]), 32'(p1 + 1));
      chk("d1_len", 32'(last[1]), 32'(RC));
      chk("d1_others", 32'(pulses[0] + pulses[2]), 32'(p0 + p2));

      // Restart while busy is ignored
      p0 = pulses[0];
      axi_write(12'h004, 32'h1, 4'hF, 0, RESP_OKAY, 1, 0);
      tick(5);
      axi_write(12'h004, 32'h1, 4'hF, 0, RESP_OKAY, 1, 0);
      tick(30);
      chk("d0_single_pulse", 32'(pulses[0]), 32'(p0 + 1));
      chk("d0_len", 32'(last[0]), 32'(RC));

      // Zero strobes start nothing
      for (int i = 0; i < int'(ND); i++) snap[i] = pulses[i];
      axi_write(12'h004, 32'hFFFF_FFFF, 4'h0, -1, RESP_OKAY, 1, 0);
      tick(20);
      for (int i = 0; i < int'(ND); i++)
         chk($sformatf("nostrb_pulses%0d", i), 32'(pulses[i]), 32'(snap[i]));
      axi_read(12'h004, 32'h0, RESP_OKAY, 1);

      // Register map and error responses
      axi_read(12'h000, TS, RESP_OKAY, 1);
      axi_read(12'h010, 32'h0, RESP_SLVERR, 1);
      axi_read(12'hFFC, 32'h0, RESP_SLVERR, 1);
      axi_read(12'h00B, 32'h7, RESP_OKAY, 1);
      axi_write(12'h010, 32'h7, 4'hF, -1, RESP_SLVERR, 1, 0);
      axi_write(12'h000, 32'hFFFF_FFFF, 4'hF, -1, RESP_OKAY, 1, 0);
      axi_write(12'h008, 32'h0, 4'hF, 1, RESP_OKAY, 1, 0);
      axi_read(12'h000, TS, RESP_OKAY, 1);
      axi_read(12'h008, 32'h7, RESP_OKAY, 1);

      // R held while rready low
      bus.rready = 1'b0;
      axi_read(12'h000, TS, RESP_OKAY, 0);
      stable_ok = 1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (!(bus.rvalid === 1'b1 && bus.rdata === TS && bus.rresp === RESP_OKAY)) stable_ok = 0;
      end
      chk("r_stall_stable", 32'(stable_ok), 32'd1);
      tick(1);
      bus.rready = 1'b1;
      drain_r();

      // B held while bready low
      bus.bready = 1'b0;
      axi_write(12'h010, 32'h0, 4'hF, -1, RESP_SLVERR, 0, 0);
      tick(2);
      stable_ok = 1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (!(bus.bvalid === 1'b1 && bus.bresp === RESP_SLVERR)) stable_ok = 0;
      end
      chk("b_stall_stable", 32'(stable_ok), 32'd1);
      tick(1);
      bus.bready = 1'b1;
      drain_b();

      // Reset mid-ASSERT with a pending write response
      bus.bready = 1'b0;
      axi_write(12'h004, 32'h1, 4'hF, -1, RESP_OKAY, 0, 0);
      tick(4);
      chk("pre_rst_bvalid", 32'(bus.bvalid), 32'd1);
      chk("pre_rst_d0_low", 32'(mod_rstn[0]), 32'd0);
      for (int i = 0; i < int'(ND); i++) snap[i] = pulses[i];
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_bvalid", 32'(bus.bvalid), 32'd0);
      chk("midrst_mod_rstn", 32'(mod_rstn), 32'h0);
      chk("midrst_readies", {29'd0, bus.awready, bus.wready, bus.arready}, 32'h7);
      bq.delete();
      tick(3);
      @(posedge clk);
      #1 rst_n = 1'b1;
      bus.bready = 1'b1;
      tick(30);
      for (int i = 0; i < int'(ND); i++) begin
         chk($sformatf("rerun_pulses%0d", i), 32'(pulses[i]), 32'(snap[i] + 1));
         chk($sformatf("rerun_len%0d", i), 32'(last[i]), 32'(RC));
      end
      chk("rerun_no_bvalid", 32'(bus.bvalid), 32'd0);
      axi_read(12'h008, 32'h7, RESP_OKAY, 1);
      axi_read(12'h004, 32'h0, RESP_OKAY, 1);

      tick(5);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axil_reset_ctrl_regs.md
# axil_reset_ctrl_regs

AXI4-Lite responder for the shell's reset-control register space, sitting behind the QDMA AXI-Lite master. It accepts host writes to the reset register and runs one reset sequence per domain: assert, hold, release, then wait for the domain's done indication. It reports per-domain completion through the status register, which is what the host polls after issuing a reset.

## Interface
- `NUM_DOMAIN`, 3: number of reset domains (1..32); bit i of the data registers maps to domain i.
- `RESET_CYCLES`, 16: cycles each `mod_rstn[i]` is held low per sequence (≥1).
- `BUILD_TIMESTAMP`, 32'h01010000: value returned at offset 0x000.
- `axil_aclk` in 1: the only clock.
- `axil_aresetn` in 1: asynchronous, active-low reset.
- `s_axil_awvalid`/`s_axil_awready` in/out 1: write address handshake.
- `s_axil_awaddr` in 12: write byte address.
- `s_axil_wvalid`/`s_axil_wready` in/out 1: write data handshake.
- `s_axil_wdata` in 32: write data.
- `s_axil_wstrb` in 4: write byte strobes.
- `s_axil_bvalid`/`s_axil_bready` out/in 1: write response handshake.
- `s_axil_bresp` out 2: write response code.
- `s_axil_arvalid`/`s_axil_arready` in/out 1: read address handshake.
- `s_axil_araddr` in 12: read byte address.
- `s_axil_rvalid`/`s_axil_rready` out/in 1: read data handshake.
- `s_axil_rdata` out 32: read data.
- `s_axil_rresp` out 2: read response code.
- `mod_rstn` out NUM_DOMAIN: active-low reset to each domain.
- `mod_rst_done` in NUM_DOMAIN: per-domain done level. Must already be synchronous to `axil_aclk`.

## Operation
- Register map, by `addr[11:2]`; `addr[1:0]` is ignored:
  - 0x000 TIMESTAMP: read-only.
  - 0x004 RESET: write-1-to-start; reads return the `busy` vector.
  - 0x008 STATUS: read-only; returns the `done` vector.
  - Other offsets: reads return 0 with SLVERR (2'b10); writes are discarded with SLVERR.
  - Writes to 0x000 or 0x008 are discarded with OKAY.
- Unused upper data bits read as 0.
- Write to RESET: bit i starts a sequence only if `wdata[i]`=1, `wstrb[i/8]`=1 and domain i is in IDLE or DONE. Such writes to a busy domain are ignored, and the sequence is not restarted.
- Per-domain FSM:
  - IDLE → ASSERT on start.
  - ASSERT: `mod_rstn`=0 and the counter increments. Leave for WAIT_DONE when the counter reaches RESET_CYCLES-1.
  - WAIT_DONE: `mod_rstn`=1. Go to DONE when `mod_rst_done[i]`=1.
  - DONE → ASSERT on a new start.
- `busy[i]` = state ∈ {ASSERT, WAIT_DONE}.
- `done[i]` = state == DONE. `done[i]` is cleared on the cycle a new sequence starts.
- Counter width is `$clog2(RESET_CYCLES+1)`. It is zeroed on entry to ASSERT and never wraps.
- Power-up: during `axil_aresetn`=0 every domain is in ASSERT with counter 0. After reset release each domain completes a full sequence automatically, with no host write needed.

## Timing
- Reset values:
  - `mod_rstn`=0; `done`=0; `busy`=all-ones.
  - `awready`=`wready`=`arready`=1.
  - `bvalid`=`rvalid`=0; `bresp`=`rresp`=0; `rdata`=0.
- Write channel:
  - AW and W are accepted independently, in the same or different cycles. Each ready drops after its own handshake.
  - The register update and `bvalid`=1 occur on the cycle after both have been captured.
  - `bvalid` holds until `bready`. Both readies return high on the cycle after the B handshake.
  - At most one write is outstanding.
- Read channel:
  - `arready` drops after the AR handshake.
  - `rvalid`/`rdata`/`rresp` are registered and valid on the next cycle. They hold stable until `rready`.
  - `arready` re-asserts on the cycle after the R handshake.
  - The read sees register state as of the AR handshake cycle.
- Simultaneous read and write: the channels are independent. A STATUS read captured on the same cycle a RESET write takes effect returns the pre-write value.
- ASSERT lasts exactly RESET_CYCLES cycles. `mod_rstn` rises on the first WAIT_DONE cycle.
- DONE is entered one cycle after `mod_rst_done` is sampled high in WAIT_DONE. If `mod_rst_done` is already high, WAIT_DONE lasts exactly 1 cycle.
- `axil_aresetn` asserted mid-transaction or mid-sequence:
  - All outputs take their reset values immediately.
  - Any pending AXI response is dropped.

## Structure
- Package `axil_reset_ctrl_pkg` holds:
  - Register offset constants: `REG_TIMESTAMP`, `REG_RESET`, `REG_STATUS`.
  - Response codes `RESP_OKAY`, `RESP_SLVERR`.
  - Domain state enum `rst_state_t` (IDLE, ASSERT, WAIT_DONE, DONE).
- Sub-module `reset_domain_fsm`:
  - Ports: `start`, `mod_rst_done`, `mod_rstn`, `busy`, `done`.
  - Instantiated NUM_DOMAIN times in a generate loop.
  - The top level contains only the AXI-Lite channel logic and read mux.

## Test plan
- Power-up: release reset, no AXI traffic → each `mod_rstn` low for 16 cycles, then high; with `mod_rst_done` tied high, STATUS reads 0x7 and RESET reads 0x0.
- Write 0x004=0x2 with AW two cycles before W, then read STATUS on the same cycle as the write effect → the read returns 0x7. Domain 1 `mod_rstn` is low 16 cycles. With `mod_rst_done[1]` held low 50 cycles, RESET reads 0x2 and STATUS reads 0x5, then STATUS reads 0x7.
- Write 0x004=0x1 twice, 5 cycles apart → a single 16-cycle assertion on domain 0; `bresp`=OKAY both times.
- Write 0x004=0xFFFF_FFFF with `wstrb`=4'b0000 → no domain resets; OKAY.
- Read 0x000 → 0x01010000, OKAY. Read 0x010 → 0, SLVERR. Write 0x010 → SLVERR. Hold `bready`/`rready` low 10 cycles → outputs stable.
- Assert `axil_aresetn` mid-ASSERT with `bvalid` pending → `bvalid`=0 immediately and all `mod_rstn`=0. After release, the auto-sequence reruns.
